// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: FSM states,
// opcode/funct values, ALU operation codes and datapath select encodings.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADR   = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    I_EXEC    = 4'd9,
    I_WB      = 4'd10,
    JUMP      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] ALUSRC_B_REG    = 2'b00;
  localparam logic [1:0] ALUSRC_B_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRC_B_IMM    = 2'b10;
  localparam logic [1:0] ALUSRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Immediate-format ALU instructions handled by I_EXEC/I_WB.
  function automatic logic is_itype(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Unified instruction/data memory port with req/ready handshake.
interface multicycle_control_unit_if;
  logic mem_req_o;
  logic mem_write_o;
  logic iord_o;
  logic mem_ready_i;

  modport master (output mem_req_o, output mem_write_o, output iord_o, input mem_ready_i);
  modport slave  (input mem_req_o, input mem_write_o, input iord_o, output mem_ready_i);
endinterface

// File: rtl/alu_decoder.sv
// Combinational op/funct to ALU operation decode, shared by R_EXEC and I_EXEC.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       zero_ext,
  output logic       funct_illegal
);

  // Select ALU operation; unknown R-type funct raises funct_illegal.
  always_comb begin
    alu_control   = ALU_ADD;
    zero_ext      = 1'b0;
    funct_illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_control = ALU_ADD;
          FUNCT_SUB: alu_control = ALU_SUB;
          FUNCT_AND: alu_control = ALU_AND;
          FUNCT_OR:  alu_control = ALU_OR;
          FUNCT_SLT: alu_control = ALU_SLT;
          default:   funct_illegal = 1'b1;
        endcase
      end
      OP_ANDI: begin
        alu_control = ALU_AND;
        zero_ext    = 1'b1;
      end
      OP_ORI: begin
        alu_control = ALU_OR;
        zero_ext    = 1'b1;
      end
      OP_SLTI: alu_control = ALU_SLT;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute over a shared
// ALU and a single handshaked memory port, counts retired instructions.
module multicycle_control_unit
  import mips_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [5:0]                op_i,
  input  logic [5:0]                funct_i,
  input  logic                      zero_i,
  multicycle_control_unit_if.master mem,
  output logic                      ir_write_o,
  output logic                      pc_en_o,
  output logic [1:0]                pc_src_o,
  output logic                      alu_src_a_o,
  output logic [1:0]                alu_src_b_o,
  output logic                      zero_ext_o,
  output logic [3:0]                alu_control_o,
  output logic                      reg_dst_o,
  output logic                      mem_to_reg_o,
  output logic                      reg_write_o,
  output logic                      illegal_o,
  output logic [CNT_WIDTH-1:0]      retired_o,
  output logic [3:0]                state_o
);

  state_t                state_r;
  state_t                state_next_s;
  logic [CNT_WIDTH-1:0]  retired_r;
  logic                  rdy_s;
  logic                  retire_s;
  logic                  mem_req_s;
  logic                  mem_write_s;
  logic                  ir_write_s;
  logic                  pc_en_s;
  logic                  reg_write_s;
  logic                  illegal_s;
  logic [3:0]            dec_alu_s;
  logic                  dec_zext_s;
  logic                  dec_illegal_s;

  assign rdy_s = MEM_HANDSHAKE ? mem.mem_ready_i : 1'b1;

  alu_decoder u_alu_decoder (
    .op            (op_i),
    .funct         (funct_i),
    .alu_control   (dec_alu_s),
    .zero_ext      (dec_zext_s),
    .funct_illegal (dec_illegal_s)
  );

  // Next-state and per-state control decode.
  always_comb begin
    state_next_s  = state_r;
    retire_s      = 1'b0;
    mem_req_s     = 1'b0;
    mem_write_s   = 1'b0;
    ir_write_s    = 1'b0;
    pc_en_s       = 1'b0;
    reg_write_s   = 1'b0;
    illegal_s     = 1'b0;
    mem.iord_o    = 1'b0;
    pc_src_o      = PCSRC_ALU;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = ALUSRC_B_REG;
    zero_ext_o    = 1'b0;
    alu_control_o = ALU_ADD;
    reg_dst_o     = 1'b0;
    mem_to_reg_o  = 1'b0;
    case (state_r)
      FETCH: begin
        mem_req_s    = 1'b1;
        alu_src_b_o  = ALUSRC_B_FOUR;
        ir_write_s   = rdy_s;
        pc_en_s      = rdy_s;
        state_next_s = rdy_s ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b_o = ALUSRC_B_IMM_SH;
        if ((op_i == OP_LW) || (op_i == OP_SW)) begin
          state_next_s = MEM_ADR;
        end else if (op_i == OP_RTYPE) begin
          state_next_s = R_EXEC;
        end else if ((op_i == OP_BEQ) || (op_i == OP_BNE)) begin
          state_next_s = BRANCH;
        end else if (is_itype(op_i)) begin
          state_next_s = I_EXEC;
        end else if (op_i == OP_J) begin
          state_next_s = JUMP;
        end else begin
          illegal_s    = 1'b1;
          state_next_s = FETCH;
        end
      end
      MEM_ADR: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = ALUSRC_B_IMM;
        state_next_s = (op_i == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mem_req_s    = 1'b1;
        mem.iord_o   = 1'b1;
        state_next_s = rdy_s ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_o = 1'b1;
        retire_s     = 1'b1;
        state_next_s = FETCH;
      end
      MEM_WRITE: begin
        mem_req_s    = 1'b1;
        mem_write_s  = 1'b1;
        mem.iord_o   = 1'b1;
        retire_s     = rdy_s;
        state_next_s = rdy_s ? FETCH : MEM_WRITE;
      end
      R_EXEC: begin
        alu_src_a_o   = 1'b1;
        alu_control_o = dec_alu_s;
        illegal_s     = dec_illegal_s;
        state_next_s  = dec_illegal_s ? FETCH : R_WB;
      end
      R_WB: begin
        reg_write_s  = 1'b1;
        reg_dst_o    = 1'b1;
        retire_s     = 1'b1;
        state_next_s = FETCH;
      end
      BRANCH: begin
        alu_src_a_o   = 1'b1;
        alu_control_o = ALU_SUB;
        pc_src_o      = PCSRC_ALUOUT;
        pc_en_s       = ((op_i == OP_BEQ) && zero_i) || ((op_i == OP_BNE) && !zero_i);
        retire_s      = 1'b1;
        state_next_s  = FETCH;
      end
      I_EXEC: begin
        alu_src_a_o   = 1'b1;
        alu_src_b_o   = ALUSRC_B_IMM;
        alu_control_o = dec_alu_s;
        zero_ext_o    = dec_zext_s;
        state_next_s  = I_WB;
      end
      I_WB: begin
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
        state_next_s = FETCH;
      end
      JUMP: begin
        pc_src_o     = PCSRC_JUMP;
        pc_en_s      = 1'b1;
        retire_s     = 1'b1;
        state_next_s = FETCH;
      end
      default: state_next_s = FETCH;
    endcase
  end

  // Strobes are held low for as long as reset is asserted, not just at the edge.
  assign mem.mem_req_o   = mem_req_s   & ~rst_i;
  assign mem.mem_write_o = mem_write_s & ~rst_i;
  assign ir_write_o      = ir_write_s  & ~rst_i;
  assign pc_en_o         = pc_en_s     & ~rst_i;
  assign reg_write_o     = reg_write_s & ~rst_i;
  assign illegal_o       = illegal_s   & ~rst_i;
  assign retired_o       = retired_r;
  assign state_o         = state_r;

  // State register and retired-instruction counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= FETCH;
      retired_r <= '0;
    end else begin
      state_r <= state_next_s;
      if (retire_s) begin
        retired_r <= retired_r + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed checks of the multi-cycle control FSM with hand-computed expectations.
module tb_multicycle_control_unit;
  import mips_pkg::*;

  logic        clk;
  logic        rst;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        ir_write;
  logic        pc_en;
  logic [1:0]  pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        zero_ext;
  logic [3:0]  alu_control;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        reg_write;
  logic        illegal;
  logic [31:0] retired;
  logic [3:0]  state;

  int vectors     = 0;
  int miscompares = 0;

  multicycle_control_unit_if mem_if ();

  multicycle_control_unit #(.MEM_HANDSHAKE(1'b1), .CNT_WIDTH(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .op_i          (op),
    .funct_i       (funct),
    .zero_i        (zero),
    .mem           (mem_if),
    .ir_write_o    (ir_write),
    .pc_en_o       (pc_en),
    .pc_src_o      (pc_src),
    .alu_src_a_o   (alu_src_a),
    .alu_src_b_o   (alu_src_b),
    .zero_ext_o    (zero_ext),
    .alu_control_o (alu_control),
    .reg_dst_o     (reg_dst),
    .mem_to_reg_o  (mem_to_reg),
    .reg_write_o   (reg_write),
    .illegal_o     (illegal),
    .retired_o     (retired),
    .state_o       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    op = OP_LW;
    funct = 6'd0;
    zero = 1'b0;
    mem_if.mem_ready_i = 1'b1;
    #2;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_mem_req", 32'(mem_if.mem_req_o), 32'd0);
    chk("rst_ir_write", 32'(ir_write), 32'd0);
    chk("rst_pc_en", 32'(pc_en), 32'd0);

    // lw, zero wait: FETCH DECODE MEM_ADR MEM_READ MEM_WB
    cyc(); rst = 1'b0; #1;
    chk("lw_fetch_state", 32'(state), 32'd0);
    chk("lw_fetch_req", 32'(mem_if.mem_req_o), 32'd1);
    chk("lw_fetch_iord", 32'(mem_if.iord_o), 32'd0);
    chk("lw_fetch_irw", 32'(ir_write), 32'd1);
    chk("lw_fetch_pcen", 32'(pc_en), 32'd1);
    chk("lw_fetch_srcb", 32'(alu_src_b), 32'd1);
    chk("lw_fetch_alu", 32'(alu_control), 32'h2);
    cyc(); #1;
    chk("lw_dec_state", 32'(state), 32'd1);
    chk("lw_dec_srcb", 32'(alu_src_b), 32'd3);
    chk("lw_dec_req", 32'(mem_if.mem_req_o), 32'd0);
    cyc(); #1;
    chk("lw_adr_state", 32'(state), 32'd2);
    chk("lw_adr_srca", 32'(alu_src_a), 32'd1);
    chk("lw_adr_srcb", 32'(alu_src_b), 32'd2);
    cyc(); #1;
    chk("lw_rd_state", 32'(state), 32'd3);
    chk("lw_rd_req", 32'(mem_if.mem_req_o), 32'd1);
    chk("lw_rd_iord", 32'(mem_if.iord_o), 32'd1);
    chk("lw_rd_regw", 32'(reg_write), 32'd0);
    cyc(); #1;
    chk("lw_wb_state", 32'(state), 32'd4);
    chk("lw_wb_regw", 32'(reg_write), 32'd1);
    chk("lw_wb_m2r", 32'(mem_to_reg), 32'd1);
    chk("lw_wb_regdst", 32'(reg_dst), 32'd0);
    chk("lw_wb_retired", retired, 32'd0);
    cyc(); op = OP_SW; #1;
    chk("lw_done_state", 32'(state), 32'd0);
    chk("lw_done_retired", retired, 32'd1);

    // sw with three wait cycles in MEM_WRITE
    cyc(); #1;
    chk("sw_dec_state", 32'(state), 32'd1);
    cyc(); #1;
    chk("sw_adr_state", 32'(state), 32'd2);
    for (int i = 0; i < 3; i++) begin
      cyc(); mem_if.mem_ready_i = 1'b0; #1;
      chk("sw_wait_state", 32'(state), 32'd5);
      chk("sw_wait_req", 32'(mem_if.mem_req_o), 32'd1);
      chk("sw_wait_wr", 32'(mem_if.mem_write_o), 32'd1);
      chk("sw_wait_iord", 32'(mem_if.iord_o), 32'd1);
      chk("sw_wait_retired", retired, 32'd1);
    end
    cyc(); mem_if.mem_ready_i = 1'b1; #1;
    chk("sw_last_state", 32'(state), 32'd5);
    chk("sw_last_wr", 32'(mem_if.mem_write_o), 32'd1);
    cyc(); op = OP_BEQ; zero = 1'b1; #1;
    chk("sw_done_state", 32'(state), 32'd0);
    chk("sw_done_retired", retired, 32'd2);

    // beq taken, then bne not taken with zero=1
    cyc(); cyc(); #1;
    chk("beq_state", 32'(state), 32'd8);
    chk("beq_pcen", 32'(pc_en), 32'd1);
    chk("beq_pcsrc", 32'(pc_src), 32'd1);
    chk("beq_alu", 32'(alu_control), 32'h6);
    cyc(); op = OP_BNE; #1;
    chk("beq_retired", retired, 32'd3);
    cyc(); cyc(); #1;
    chk("bne_state", 32'(state), 32'd8);
    chk("bne_pcen", 32'(pc_en), 32'd0);
    cyc(); op = OP_RTYPE; funct = 6'b101010; #1;
    chk("bne_retired", retired, 32'd4);

    // R-type slt, then illegal funct
    cyc(); cyc(); #1;
    chk("slt_state", 32'(state), 32'd6);
    chk("slt_alu", 32'(alu_control), 32'h7);
    chk("slt_srcb", 32'(alu_src_b), 32'd0);
    chk("slt_illegal", 32'(illegal), 32'd0);
    cyc(); #1;
    chk("slt_wb_state", 32'(state), 32'd7);
    chk("slt_wb_regw", 32'(reg_write), 32'd1);
    chk("slt_wb_regdst", 32'(reg_dst), 32'd1);
    chk("slt_wb_m2r", 32'(mem_to_reg), 32'd0);
    cyc(); funct = 6'b111111; #1;
    chk("slt_retired", retired, 32'd5);
    cyc(); cyc(); #1;
    chk("badf_illegal", 32'(illegal), 32'd1);
    chk("badf_regw", 32'(reg_write), 32'd0);
    cyc(); op = 6'b111111; #1;
    chk("badf_state", 32'(state), 32'd0);
    chk("badf_illegal_end", 32'(illegal), 32'd0);
    chk("badf_retired", retired, 32'd5);

    // illegal opcode flagged in DECODE
    cyc(); #1;
    chk("badop_illegal", 32'(illegal), 32'd1);
    cyc(); op = OP_ORI; #1;
    chk("badop_state", 32'(state), 32'd0);
    chk("badop_retired", retired, 32'd5);

    // ori
    cyc(); cyc(); #1;
    chk("ori_state", 32'(state), 32'd9);
    chk("ori_zext", 32'(zero_ext), 32'd1);
    chk("ori_alu", 32'(alu_control), 32'h1);
    chk("ori_srcb", 32'(alu_src_b), 32'd2);
    cyc(); #1;
    chk("ori_wb_state", 32'(state), 32'd10);
    chk("ori_wb_regw", 32'(reg_write), 32'd1);
    chk("ori_wb_regdst", 32'(reg_dst), 32'd0);
    chk("ori_wb_zext", 32'(zero_ext), 32'd0);
    cyc(); op = OP_J; #1;
    chk("ori_retired", retired, 32'd6);

    // jump, then FETCH stalled by memory
    cyc(); cyc(); #1;
    chk("j_state", 32'(state), 32'd11);
    chk("j_pcen", 32'(pc_en), 32'd1);
    chk("j_pcsrc", 32'(pc_src), 32'd2);
    cyc(); mem_if.mem_ready_i = 1'b0; op = OP_LW; #1;
    chk("j_retired", retired, 32'd7);
    chk("stall_irw", 32'(ir_write), 32'd0);
    chk("stall_pcen", 32'(pc_en), 32'd0);
    chk("stall_req", 32'(mem_if.mem_req_o), 32'd1);
    cyc(); mem_if.mem_ready_i = 1'b1; #1;
    chk("stall_state", 32'(state), 32'd0);
    chk("stall_irw_go", 32'(ir_write), 32'd1);

    // reset during MEM_READ wait
    cyc(); cyc(); cyc(); mem_if.mem_ready_i = 1'b0; #1;
    chk("rr_state", 32'(state), 32'd3);
    cyc(); #1;
    chk("rr_wait_state", 32'(state), 32'd3);
    mem_if.mem_ready_i = 1'b1;
    rst = 1'b1; #1;
    chk("rr_state_now", 32'(state), 32'd0);
    chk("rr_req", 32'(mem_if.mem_req_o), 32'd0);
    chk("rr_irw", 32'(ir_write), 32'd0);
    chk("rr_pcen", 32'(pc_en), 32'd0);
    chk("rr_regw", 32'(reg_write), 32'd0);
    chk("rr_retired", retired, 32'd0);
    cyc(); #1;
    chk("rr_hold_state", 32'(state), 32'd0);
    chk("rr_hold_req", 32'(mem_if.mem_req_o), 32'd0);
    cyc(); rst = 1'b0; mem_if.mem_ready_i = 1'b0; #1;
    chk("rr_rel_state", 32'(state), 32'd0);
    chk("rr_rel_req", 32'(mem_if.mem_req_o), 32'd1);
    chk("rr_rel_iord", 32'(mem_if.iord_o), 32'd0);
    chk("rr_rel_retired", retired, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Control FSM for the multi-cycle 32-bit MIPS core. It replaces the single-cycle combinational controller.
- One unified instruction/data memory port, guarded by a req/ready handshake, so memory can insert any number of wait states.
- Decodes op/funct from the instruction register and sequences the shared ALU, the IR/PC enables and register-file writes.
- Provides a retired-instruction counter and an illegal-instruction strobe.

Parameters:
- MEM_HANDSHAKE, 1: 1 = honour mem_ready_i; 0 = treat mem_ready_i as constant 1 (zero-wait memory).
- CNT_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- op_i  in  6  IR[31:26].
- funct_i  in  6  IR[5:0].
- zero_i  in  1  ALU zero flag.
- mem_ready_i  in  1  memory accepted or completed the current request.
- mem_req_o  out  1  memory request, held until ready.
- mem_write_o  out  1  request is a store.
- iord_o  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write_o  out  1  load the IR.
- pc_en_o  out  1  PC enable (write or taken branch).
- pc_src_o  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_src_a_o  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b_o  out  2  ALU B select: 00 = register B, 01 = const 4, 10 = extended imm, 11 = imm<<2.
- zero_ext_o  out  1  zero-extend imm (andi/ori).
- alu_control_o  out  4  ALU operation.
- reg_dst_o  out  1  destination select: 1 = rd, 0 = rt.
- mem_to_reg_o  out  1  write-back source: 1 = memory data, 0 = ALUOut.
- reg_write_o  out  1  register-file write.
- illegal_o  out  1  one-cycle pulse on an undecodable instruction.
- retired_o  out  CNT_WIDTH  count of completed instructions.
- state_o  out  4  current state, for debug.

Behaviour:
- States:
  - FETCH
  - DECODE
  - MEM_ADR
  - MEM_READ
  - MEM_WB
  - MEM_WRITE
  - R_EXEC
  - R_WB
  - BRANCH
  - I_EXEC
  - I_WB
  - JUMP
- Reset (async):
  - state = FETCH, retired_o = 0.
  - While rst_i is high, all strobes (mem_req, mem_write, ir_write, pc_en, reg_write, illegal) are forced to 0.
- "rdy" means mem_ready_i, or 1 when MEM_HANDSHAKE = 0.
- FETCH:
  - mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, ADD, pc_src = 00.
  - ir_write and pc_en are asserted only in the cycle rdy = 1; the FSM then moves to DECODE. Otherwise it stays in FETCH with the request held stable.
- DECODE: alu_src_a = 0, alu_src_b = 11, ADD (branch target into ALUOut). Next state by opcode:
  - lw/sw (100011/101011) → MEM_ADR.
  - 000000 → R_EXEC.
  - beq/bne (000100/000101) → BRANCH.
  - addi/andi/ori/slti (001000/001100/001101/001010) → I_EXEC.
  - j (000010) → JUMP.
  - Anything else → illegal_o = 1 for one cycle, then FETCH; not counted as retired.
- MEM_ADR: alu_src_a = 1, alu_src_b = 10, ADD. Next state is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_req = 1, iord = 1; wait for rdy, then MEM_WB.
- MEM_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 1 → FETCH.
- MEM_WRITE: mem_req = 1, mem_write = 1, iord = 1; on rdy → FETCH.
- R_EXEC: alu_src_a = 1, alu_src_b = 00. ALU operation from funct:
  - 100000 → ADD.
  - 100010 → SUB.
  - 100100 → AND.
  - 100101 → OR.
  - 101010 → SLT.
  - Any other funct → illegal_o pulse, FETCH, no write, not retired.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0 → FETCH.
- BRANCH:
  - alu_src_a = 1, alu_src_b = 00, SUB, pc_src = 01.
  - pc_en = (beq & zero_i) | (bne & ~zero_i).
  - → FETCH.
- I_EXEC:
  - alu_src_a = 1, alu_src_b = 10.
  - ALU operation: addi → ADD, andi → AND, ori → OR, slti → SLT.
  - zero_ext = 1 for andi/ori.
- I_WB: reg_write = 1, reg_dst = 0 → FETCH.
- JUMP: pc_src = 10, pc_en = 1 → FETCH.
- Outputs are Moore decoded from the state. The exceptions are the rdy-gated strobes (ir_write, pc_en in FETCH) and the zero-gated pc_en in BRANCH.
- Unlisted outputs in any state are 0, and alu_control = ADD.
- Latency at zero-wait:
  - lw 5 cycles.
  - sw, R-type, I-type 4 cycles.
  - beq/bne, j 3 cycles.
  - Each wait cycle adds 1.
- retired_o increments on the final cycle of each legal instruction: the FETCH-bound transition out of MEM_WB, MEM_WRITE (on rdy), R_WB, BRANCH, I_WB, JUMP. It wraps modulo 2^CNT_WIDTH.
- Reset asserted mid-instruction: immediate return to FETCH. The counter clears and no partial write completes.
- ALU encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.

Decomposition:
- Package mips_pkg holds:
  - state enum state_t;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J;
  - funct constants;
  - ALU_* codes;
  - ALUSRC_B_* and PCSRC_* select encodings.
- One natural sub-module: alu_decoder (combinational op/funct → alu_control plus a funct-illegal flag), shared with R_EXEC and I_EXEC.

Test Plan:
- Zero-wait lw (op 100011), MEM_HANDSHAKE = 1, ready held 1 → states FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB. reg_write high only in cycle 5, mem_to_reg = 1, retired_o 0→1.
- sw with mem_ready_i low for 3 cycles in MEM_WRITE → mem_req = 1, mem_write = 1 and iord = 1 stable for 4 cycles; exit to FETCH on ready; total 7 cycles.
- beq with zero_i = 1 → pc_en = 1 and pc_src = 01 in BRANCH. bne with zero_i = 1 → pc_en = 0. Both retire in 3 cycles.
- R-type funct 101010 → alu_control = 0111 in R_EXEC and reg_dst = 1 in R_WB. funct 111111 → illegal_o pulses once, no reg_write, retired_o unchanged.
- ori → zero_ext = 1, alu_control = 0001, alu_src_b = 10 in I_EXEC; reg_write = 1, reg_dst = 0 in I_WB.
- rst_i asserted during MEM_READ with ready low → state_o = FETCH immediately, all strobes 0 while reset is high, retired_o = 0. After release, FETCH issues mem_req with iord = 0.
